// File: rtl/serial_addsub_if.sv
// Operand/result bundle for serial_addsub: start/busy/done handshake plus data.
interface serial_addsub_if #(
   parameter int WIDTH = 4
);
   logic             start;
   logic             mode;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             cb;
   logic             overflow;

   modport master (output start, mode, a, b,
                   input  busy, done, result, cb, overflow);
   modport slave  (input  start, mode, a, b,
                   output busy, done, result, cb, overflow);
endinterface

// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor: one full add/sub cell, LSB first, WIDTH+1 busy cycles.
// result/cb/overflow are loaded only on entry to DONE and hold until the next completion.
module serial_addsub #(
   parameter int WIDTH = 4
) (
   input logic           clk,
   input logic           reset,
   serial_addsub_if.slave bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             mode_q, mode_d, chain_q, chain_d;
   logic             cb_q, cb_d, ovf_q, ovf_d;
   logic             busy_q, busy_d, done_q, done_d;

   logic ai, bi, sum_bit, chain_out;

   // Shared cell: the sum/difference bit is the same XOR; only the chain term differs.
   assign ai        = a_q[0];
   assign bi        = b_q[0];
   assign sum_bit   = ai ^ bi ^ chain_q;
   assign chain_out = mode_q ? ((~ai & bi) | (~(ai ^ bi) & chain_q))
                             : ((ai & bi) | (chain_q & (ai ^ bi)));

   always_comb begin
      // NOTE: every _d gets a default before the case so no path leaves one unassigned (no latches).
      state_d  = state_q;
      cnt_d    = cnt_q;
      a_d      = a_q;
      b_d      = b_q;
      acc_d    = acc_q;
      mode_d   = mode_q;
      chain_d  = chain_q;
      result_d = result_q;
      cb_d     = cb_q;
      ovf_d    = ovf_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               mode_d  = bus.mode;
               chain_d = 1'b0;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            a_d     = a_q >> 1;
            b_d     = b_q >> 1;
            chain_d = chain_out;
            acc_d   = {sum_bit, acc_q[WIDTH-1:1]};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // chain_q is the carry/borrow into the MSB, chain_out the one leaving it.
               result_d = {sum_bit, acc_q[WIDTH-1:1]};
               cb_d     = chain_out;
               ovf_d    = chain_q ^ chain_out;
               done_d   = 1'b1;
               state_d  = DONE;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         acc_q    <= '0;
         mode_q   <= 1'b0;
         chain_q  <= 1'b0;
         result_q <= '0;
         cb_q     <= 1'b0;
         ovf_q    <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         a_q      <= a_d;
         b_q      <= b_d;
         acc_q    <= acc_d;
         mode_q   <= mode_d;
         chain_q  <= chain_d;
         result_q <= result_d;
         cb_q     <= cb_d;
         ovf_q    <= ovf_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.result   = result_q;
   assign bus.cb       = cb_q;
   assign bus.overflow = ovf_q;
endmodule
